// File: rtl/life_pattern_loader_if.sv
// Control bus between the pattern loader, its host and the 4x4 life array.
// master = loader side; slave = host/array side.
interface life_pattern_loader_if #(
    parameter int unsigned GEN_W = 16
);
    logic [15:0]      pattern;
    logic             load_req;
    logic             run_req;
    logic [1:0]       row;
    logic [1:0]       col;
    logic             val;
    logic             write_enb;
    logic             run;
    logic             busy;
    logic             done;
    logic [GEN_W-1:0] gen_count;

    modport master (
        input  pattern, load_req, run_req,
        output row, col, val, write_enb, run, busy, done, gen_count
    );

    modport slave (
        output pattern, load_req, run_req,
        input  row, col, val, write_enb, run, busy, done, gen_count
    );
endinterface

// File: rtl/life_pattern_loader.sv
// Loads a 16-bit seed into life_array_4x4 one cell per clock (k = 4*col + row),
// then paces generations with a one-cycle run pulse every TICK_DIV clocks.
module life_pattern_loader #(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned GEN_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    life_pattern_loader_if.master bus
);
    localparam int unsigned       TICK_W    = 16;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, RUN} state_e;

    state_e            state_q, state_d;
    logic [3:0]        k_q, k_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [15:0]       pattern_q, pattern_d;
    logic              loaded_q, loaded_d;
    logic [1:0]        row_q, row_d;
    logic [1:0]        col_q, col_d;
    logic              val_q, val_d;
    logic              write_enb_q, write_enb_d;
    logic              run_q, run_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [GEN_W-1:0]  gen_count_q, gen_count_d;
    logic              start_load;

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        tick_d      = tick_q;
        pattern_d   = pattern_q;
        loaded_d    = loaded_q;
        row_d       = row_q;
        col_d       = col_q;
        val_d       = val_q;
        gen_count_d = gen_count_q;
        write_enb_d = 1'b0;
        run_d       = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        start_load  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.load_req) begin
                    start_load = 1'b1;
                end else if (bus.run_req && loaded_q) begin
                    state_d = RUN;
                    tick_d  = '0;
                end
            end
            LOAD: begin
                if (k_q == 4'd15) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    gen_count_d = '0;
                    tick_d      = '0;
                    loaded_d    = 1'b1;
                end else begin
                    k_d         = k_q + 4'd1;
                    write_enb_d = 1'b1;
                    busy_d      = 1'b1;
                    row_d       = k_d[1:0];
                    col_d       = k_d[3:2];
                    val_d       = pattern_q[k_d];
                end
            end
            DONE: begin
                state_d = bus.run_req ? RUN : IDLE;
                tick_d  = '0;
            end
            RUN: begin
                // A new load aborts the run even if run_req has dropped.
                if (bus.load_req) begin
                    start_load = 1'b1;
                end else if (!bus.run_req) begin
                    state_d = IDLE;
                    tick_d  = '0;
                end else begin
                    tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_load) begin
            state_d     = LOAD;
            pattern_d   = bus.pattern;
            k_d         = 4'd0;
            tick_d      = '0;
            write_enb_d = 1'b1;
            busy_d      = 1'b1;
            row_d       = 2'd0;
            col_d       = 2'd0;
            val_d       = bus.pattern[0];
        end

        // Pulse on the cycle whose tick value is TICK_DIV-1; gen_count tracks pulses issued.
        run_d = (state_d == RUN) && (tick_d == TICK_LAST);
        if (run_d) begin
            gen_count_d = gen_count_q + GEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            tick_q      <= '0;
            pattern_q   <= '0;
            loaded_q    <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            val_q       <= 1'b0;
            write_enb_q <= 1'b0;
            run_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            gen_count_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            tick_q      <= tick_d;
            pattern_q   <= pattern_d;
            loaded_q    <= loaded_d;
            row_q       <= row_d;
            col_q       <= col_d;
            val_q       <= val_d;
            write_enb_q <= write_enb_d;
            run_q       <= run_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            gen_count_q <= gen_count_d;
        end
    end

    assign bus.row       = row_q;
    assign bus.col       = col_q;
    assign bus.val       = val_q;
    assign bus.write_enb = write_enb_q;
    assign bus.run       = run_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.gen_count = gen_count_q;
endmodule

// File: tb/tb_life_pattern_loader.sv
// Directed bench for life_pattern_loader with a small non-wrapping 4x4 Life array model
// standing in for life_array_4x4 downstream.
module tb_life_pattern_loader;
    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   run_pulses;
    int   inv_viol;
    logic [15:0] alive;
    logic [15:0] pat;

    life_pattern_loader_if #(.GEN_W(16)) bus ();

    life_pattern_loader #(.TICK_DIV(4), .GEN_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] life_step(input logic [15:0] c);
        logic [15:0] n;
        int cnt;
        n = '0;
        for (int cc = 0; cc < 4; cc++) begin
            for (int rr = 0; rr < 4; rr++) begin
                cnt = 0;
                for (int dc = -1; dc <= 1; dc++) begin
                    for (int dr = -1; dr <= 1; dr++) begin
                        if ((dc != 0 || dr != 0) && cc + dc >= 0 && cc + dc < 4 &&
                            rr + dr >= 0 && rr + dr < 4)
                            cnt += int'(c[4*(cc+dc) + rr + dr]);
                    end
                end
                n[4*cc+rr] = (cnt == 3) || (cnt == 2 && c[4*cc+rr]);
            end
        end
        return n;
    endfunction

    // Array model plus pulse / invariant monitors.
    initial alive = '0;
    initial run_pulses = 0;
    initial inv_viol = 0;
    always @(posedge clk) begin
        if (bus.write_enb)
            alive[{bus.col, bus.row}] <= bus.val;
        else if (bus.run)
            alive <= life_step(alive);
        if (bus.run)
            run_pulses <= run_pulses + 1;
        if (bus.write_enb && bus.run)
            inv_viol <= inv_viol + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // n RUN cycles starting at the first RUN cycle; pulse every 4th; alive toggles with steps applied.
    task automatic run_cycles(input string tag, input int g0, input int n,
                              input logic [15:0] a_even, input logic [15:0] a_odd);
        logic exp_run;
        int   exp_gen;
        int   applied;
        for (int c = 1; c <= n; c++) begin
            step();
            exp_run = (c % 4 == 0);
            exp_gen = g0 + c / 4;
            applied = exp_run ? exp_gen - 1 : exp_gen;
            chk($sformatf("%s_run_c%0d", tag, c), 32'(bus.run), 32'(exp_run));
            chk($sformatf("%s_gen_c%0d", tag, c), 32'(bus.gen_count), 32'(exp_gen));
            chk($sformatf("%s_alive_c%0d", tag, c), 32'(alive),
                32'((applied % 2 == 0) ? a_even : a_odd));
        end
    endtask

    initial begin
        int pulses_before;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.pattern  = '0;
        bus.load_req = 1'b0;
        bus.run_req  = 1'b0;
        repeat (3) step();
        chk("reset_outputs",
            32'({bus.row, bus.col, bus.val, bus.write_enb, bus.run, bus.busy, bus.done}), 32'd0);
        chk("reset_gen", 32'(bus.gen_count), 32'd0);
        reset = 1'b0;
        step();

        // run_req alone before any load must not run
        bus.run_req = 1'b1;
        repeat (6) step();
        chk("idle_no_run_before_load", 32'(run_pulses), 32'd0);
        chk("idle_not_busy", 32'(bus.busy), 32'd0);
        bus.run_req = 1'b0;
        step();

        // Load 0x0660; a second load_req with 0xFFFF mid-load is ignored
        pat = 16'h0660;
        bus.pattern  = pat;
        bus.load_req = 1'b1;
        step();
        bus.load_req = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("load_a_k%0d", k),
                32'({bus.write_enb, bus.busy, bus.run, bus.done, bus.row, bus.col, bus.val}),
                32'({1'b1, 1'b1, 1'b0, 1'b0, 2'(k), 2'(k >> 2), pat[k]}));
            if (k == 4) begin
                bus.pattern  = 16'hFFFF;
                bus.load_req = 1'b1;
            end
            if (k == 5)
                bus.load_req = 1'b0;
            step();
        end
        chk("load_a_done", 32'({bus.write_enb, bus.busy, bus.done}), 32'b001);
        chk("load_a_alive", 32'(alive), 32'h0660);
        step();
        chk("load_a_done_once", 32'(bus.done), 32'd0);
        chk("load_a_never_run", 32'(run_pulses), 32'd0);
        chk("load_a_idle_row_hold", 32'({bus.row, bus.col, bus.write_enb}), 32'b1111_0);

        // Blinker with run_req high: pulses every 4th clock
        bus.run_req  = 1'b1;
        bus.pattern  = 16'h0222;
        bus.load_req = 1'b1;
        step();
        bus.load_req = 1'b0;
        repeat (16) step();
        chk("blink_done", 32'(bus.done), 32'd1);
        chk("blink_gen_cleared", 32'(bus.gen_count), 32'd0);
        chk("blink_alive_seed", 32'(alive), 32'h0222);
        run_cycles("blink", 0, 12, 16'h0222, 16'h0070);

        // Drop run_req at gen_count=3 for 5 cycles, then resume
        step();
        chk("pause_tick0_run", 32'(bus.run), 32'd0);
        bus.run_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("pause_run_i%0d", i), 32'(bus.run), 32'd0);
            chk($sformatf("pause_gen_i%0d", i), 32'(bus.gen_count), 32'd3);
        end
        chk("pause_alive", 32'(alive), 32'h0070);
        bus.run_req = 1'b1;
        run_cycles("resume", 3, 12, 16'h0222, 16'h0070);

        // Abort mid-RUN with pond 0x6996 one cycle before a pulse would fire
        step();
        step();
        step();
        chk("abort_pre_run", 32'(bus.run), 32'd0);
        pat = 16'h6996;
        bus.pattern  = pat;
        bus.load_req = 1'b1;
        step();
        bus.load_req = 1'b0;
        chk("abort_run_dropped",
            32'({bus.write_enb, bus.busy, bus.run, bus.row, bus.col, bus.val}),
            32'({1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0}));
        for (int k = 1; k < 16; k++) begin
            step();
            chk($sformatf("abort_load_k%0d", k),
                32'({bus.write_enb, bus.run, bus.row, bus.col, bus.val}),
                32'({1'b1, 1'b0, 2'(k), 2'(k >> 2), pat[k]}));
        end
        step();
        chk("abort_done", 32'(bus.done), 32'd1);
        chk("abort_gen_zero", 32'(bus.gen_count), 32'd0);
        chk("abort_alive", 32'(alive), 32'h6996);
        run_cycles("pond", 0, 40, 16'h6996, 16'h6996);
        chk("pond_gen10", 32'(bus.gen_count), 32'd10);

        // Reset asserted at LOAD k=7
        bus.run_req = 1'b0;
        step();
        step();
        chk("pre_reset_idle", 32'(bus.busy), 32'd0);
        bus.pattern  = 16'hA5A5;
        bus.load_req = 1'b1;
        step();
        bus.load_req = 1'b0;
        repeat (7) step();
        chk("at_k7", 32'({bus.write_enb, bus.busy, bus.row, bus.col}), 32'b1_1_11_01);
        reset = 1'b1;
        #1;
        chk("async_reset_outputs",
            32'({bus.row, bus.col, bus.val, bus.write_enb, bus.run, bus.busy, bus.done}), 32'd0);
        chk("async_reset_gen", 32'(bus.gen_count), 32'd0);
        step();
        reset = 1'b0;
        pulses_before = run_pulses;
        bus.run_req = 1'b1;
        repeat (10) step();
        chk("post_reset_no_run", 32'(run_pulses - pulses_before), 32'd0);
        chk("post_reset_idle", 32'({bus.busy, bus.write_enb, bus.done}), 32'd0);
        chk("no_write_and_run", 32'(inv_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
